// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_ctrl_pkg
// Purpose  : Shared definitions for the A500 accelerator SPI window:
//            register indices, CTRL/STATUS bit positions, FSM encodings
//            and helpers that pack the CTRL/STATUS read words.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

  // Register index, taken from ADDRESS[2:1]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_CS_BIT  = 0;
  localparam int CTRL_DIV_LSB = 1;
  localparam int CTRL_DIV_MSB = 2;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Value returned by the reserved register and held by RDATA after reset
  localparam logic [7:0] RSVD_READ_VALUE = 8'hFF;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_WAIT = 2'd1,
    B_ACK  = 2'd2
  } bus_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } shift_state_t;

  function automatic logic [7:0] ctrl_word(input logic cs, input logic [1:0] div);
    logic [7:0] w;
    w = 8'h00;
    w[CTRL_CS_BIT] = cs;
    w[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
    return w;
  endfunction

  function automatic logic [7:0] status_word(input logic busy, input logic done);
    logic [7:0] w;
    w = 8'h00;
    w[STATUS_BUSY_BIT] = busy;
    w[STATUS_DONE_BIT] = done;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : spi_shift_engine
// Purpose  : Mode-0, MSB-first byte shifter with a 2-bit half-period
//            divider. A start pulse loads TX and the divider; eight SCK
//            pulses follow, each phase lasting DIV+1 MB_CLK cycles.
// Ports    : MB_CLK/RESET  - clock, asynchronous active-low reset
//            i_start       - load i_tx_data/i_div and begin a transfer
//            i_tx_data     - byte to send
//            i_div         - half-period divider (H = DIV+1)
//            i_miso        - serial data in
//            o_busy        - transfer in progress
//            o_fin         - last cycle of a transfer (comb.)
//            o_sck, o_mosi - serial clock / data out
//            o_rx_data     - received byte
// Revision : 1.0 - initial release
// ============================================================================
module spi_shift_engine
  import spi_ctrl_pkg::*;
(
  input  logic       MB_CLK,
  input  logic       RESET,
  input  logic       i_start,
  input  logic [7:0] i_tx_data,
  input  logic [1:0] i_div,
  input  logic       i_miso,
  output logic       o_busy,
  output logic       o_fin,
  output logic       o_sck,
  output logic       o_mosi,
  output logic [7:0] o_rx_data
);

  shift_state_t r_state;
  shift_state_t w_state_nxt;

  logic [1:0] r_cnt;
  logic [1:0] r_div;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_tx;        // bits still to send after the one on MOSI
  logic [7:0] r_rx;
  logic       r_mosi;

  logic w_sample;
  logic w_shift;
  logic w_fin;

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_LOW: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = S_HIGH;
          w_sample    = 1'b1;     // SCK rising edge
        end
      end
      S_HIGH: begin
        if (r_cnt == 2'd0) begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_IDLE;
            w_fin       = 1'b1;
          end else begin
            w_state_nxt = S_LOW;
            w_shift     = 1'b1;   // SCK falling edge
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A start may coincide with the final cycle of the previous transfer
    if (i_start) w_state_nxt = S_LOW;
  end

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt     <= 2'd0;
      r_div     <= 2'd0;
      r_bit_cnt <= 3'd0;
      r_tx      <= 7'd0;
      r_rx      <= 8'h00;
      r_mosi    <= 1'b0;
    end else begin
      if (i_start) begin
        r_div     <= i_div;
        r_cnt     <= i_div;
        r_bit_cnt <= 3'd0;
        r_tx      <= i_tx_data[6:0];
        r_mosi    <= i_tx_data[7];
      end else begin
        if (r_state != S_IDLE) begin
          r_cnt <= (r_cnt == 2'd0) ? r_div : r_cnt - 2'd1;
        end
        if (w_shift) begin
          r_mosi    <= r_tx[6];
          r_tx      <= {r_tx[5:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
      if (w_sample) r_rx <= {r_rx[6:0], i_miso};
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_sck     = (r_state == S_HIGH);
  assign o_fin     = w_fin;
  assign o_mosi    = r_mosi;
  assign o_rx_data = r_rx;

endmodule
`default_nettype wire

// File: rtl/spi_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_controller
// Purpose  : Byte-wide SPI master in the A500 accelerator SPI window.
//            Decodes CPU register accesses (DATA/CTRL/STATUS), stretches
//            the slow /DTACK while a DATA access waits for a transfer, and
//            drives the shift engine. All state is on MB_CLK.
// Ports    : RESET, MB_CLK     - async active-low reset, 7 MHz clock
//            SEL, RW, REG      - qualified window select, direction, ADDRESS[2:1]
//            WDATA / RDATA     - DATA[15:8] write / read value
//            RDATA_OE          - read data output enable (SEL & RW)
//            DTACK_N           - slow /DTACK, active-low
//            SPI_CS/SCK/MOSI/MISO - SPI pins
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_controller
  import spi_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] DIV_RESET   = 2'd0
)(
  input  logic       RESET,
  input  logic       MB_CLK,
  input  logic       SEL,
  input  logic       RW,
  input  logic [1:0] REG,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       RDATA_OE,
  output logic       DTACK_N,
  output logic       SPI_CS,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);

  bus_state_t r_bus_state;
  bus_state_t w_bus_nxt;

  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic       w_sel_s;
  logic       r_dtack_n;
  logic [7:0] r_rdata;
  logic       r_cs;
  logic [1:0] r_div;
  logic       r_done;

  logic       w_busy;
  logic       w_fin;
  logic [7:0] w_rx;
  logic       w_is_data;
  logic       w_stall;
  logic       w_do_access;
  logic       w_start;
  logic       w_data_rd;
  logic       w_ctrl_wr;
  logic [7:0] w_read_value;

  // SEL is asynchronous to MB_CLK
  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) r_sel_sync <= '0;
    else        r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], SEL};
  end
  assign w_sel_s = r_sel_sync[SYNC_STAGES-1];

  // A transfer finishing this cycle no longer stalls, so a waiting DATA
  // access completes on the same edge that BUSY clears.
  assign w_is_data = (REG == REG_DATA);
  assign w_stall   = w_is_data & w_busy & ~w_fin;

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) r_bus_state <= B_IDLE;
    else        r_bus_state <= w_bus_nxt;
  end

  always_comb begin
    w_bus_nxt   = r_bus_state;
    w_do_access = 1'b0;
    case (r_bus_state)
      B_IDLE: begin
        if (w_sel_s) begin
          if (w_stall) begin
            w_bus_nxt = B_WAIT;
          end else begin
            w_do_access = 1'b1;
            w_bus_nxt   = B_ACK;
          end
        end
      end
      B_WAIT: begin
        if (!w_sel_s) begin
          w_bus_nxt = B_IDLE;
        end else if (!w_stall) begin
          w_do_access = 1'b1;
          w_bus_nxt   = B_ACK;
        end
      end
      B_ACK: begin
        if (!w_sel_s) w_bus_nxt = B_IDLE;
      end
      default: w_bus_nxt = B_IDLE;
    endcase
  end

  assign w_start   = w_do_access & w_is_data & ~RW;
  assign w_data_rd = w_do_access & w_is_data & RW;
  assign w_ctrl_wr = w_do_access & (REG == REG_CTRL) & ~RW;

  always_comb begin
    w_read_value = RSVD_READ_VALUE;
    case (REG)
      REG_DATA:   w_read_value = w_rx;
      REG_CTRL:   w_read_value = ctrl_word(r_cs, r_div);
      REG_STATUS: w_read_value = status_word(w_busy, r_done);
      default:    w_read_value = RSVD_READ_VALUE;
    endcase
  end

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      r_dtack_n <= 1'b1;
      r_rdata   <= RSVD_READ_VALUE;
      r_cs      <= 1'b0;
      r_div     <= DIV_RESET;
      r_done    <= 1'b0;
    end else begin
      r_dtack_n <= (w_bus_nxt != B_ACK);
      if (w_do_access && RW) r_rdata <= w_read_value;
      if (w_ctrl_wr) begin
        r_cs  <= WDATA[CTRL_CS_BIT];
        r_div <= WDATA[CTRL_DIV_MSB:CTRL_DIV_LSB];
      end
      // A DATA read on the finishing edge clears DONE rather than seeing it
      r_done <= (r_done | w_fin) & ~w_data_rd;
    end
  end

  spi_shift_engine u_shift (
    .MB_CLK    (MB_CLK),
    .RESET     (RESET),
    .i_start   (w_start),
    .i_tx_data (WDATA),
    .i_div     (r_div),
    .i_miso    (SPI_MISO),
    .o_busy    (w_busy),
    .o_fin     (w_fin),
    .o_sck     (SPI_SCK),
    .o_mosi    (SPI_MOSI),
    .o_rx_data (w_rx)
  );

  // Releasing SEL releases /DTACK immediately, without waiting for the sync chain
  assign DTACK_N  = r_dtack_n | ~SEL;
  assign RDATA    = r_rdata;
  assign RDATA_OE = SEL & RW;
  assign SPI_CS   = ~r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_controller
// Purpose  : Self-checking bench for spi_bus_controller. Stimulus issues
//            CPU accesses and pushes expected acks/read data and expected
//            SPI transfers into queues; two monitors pop and compare when
//            the DUT acknowledges or toggles SCK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_controller;

  localparam int SYNC    = 2;
  localparam int ACK_LAT = SYNC + 1;

  logic       RESET;
  logic       MB_CLK;
  logic       SEL;
  logic       RW;
  logic [1:0] REG;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic       RDATA_OE;
  logic       DTACK_N;
  logic       SPI_CS;
  logic       SPI_SCK;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       lb_inv;

  spi_bus_controller #(.SYNC_STAGES(SYNC), .DIV_RESET(2'd0)) dut (
    .RESET    (RESET),
    .MB_CLK   (MB_CLK),
    .SEL      (SEL),
    .RW       (RW),
    .REG      (REG),
    .WDATA    (WDATA),
    .RDATA    (RDATA),
    .RDATA_OE (RDATA_OE),
    .DTACK_N  (DTACK_N),
    .SPI_CS   (SPI_CS),
    .SPI_SCK  (SPI_SCK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO)
  );

  // Loopback slave, optionally inverting
  assign SPI_MISO = lb_inv ? ~SPI_MOSI : SPI_MOSI;

  initial MB_CLK = 1'b0;
  always #5 MB_CLK = ~MB_CLK;

  int cyc = 0;
  always @(posedge MB_CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic rd; logic [7:0] data; int cyc; } bus_exp_t;
  typedef struct { logic [7:0] tx; int h; int start; } xfer_exp_t;
  bus_exp_t  bus_q[$];
  xfer_exp_t xfer_q[$];

  // Reference model of the register file and transfer timing
  logic       m_cs;
  logic [1:0] m_div;
  logic       m_done;
  logic [7:0] m_rx;
  logic       m_pend;   // a transfer whose end has not been folded into DONE
  int         m_end;    // cycle at which that transfer ends

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic model_reset();
    m_cs = 1'b0; m_div = 2'd0; m_done = 1'b0; m_rx = 8'h00; m_pend = 1'b0; m_end = 0;
  endtask

  // One CPU access; returns the cycle on which DTACK_N fell
  task automatic access(input logic rw, input logic [1:0] r, input logic [7:0] wd,
                        output int ack_cyc);
    bus_exp_t   e;
    xfer_exp_t  x;
    int         a;
    logic [7:0] exp_rd;
    bit         seen;
    @(negedge MB_CLK);
    RW = rw; REG = r; WDATA = wd; SEL = 1'b1;
    a = cyc + ACK_LAT;
    if (r == 2'd0 && m_pend && m_end > a) a = m_end;
    if (m_pend && m_end < a) begin m_done = 1'b1; m_pend = 1'b0; end
    exp_rd = 8'hFF;
    case (r)
      2'd0: begin
        if (rw) begin
          exp_rd = m_rx; m_done = 1'b0; m_pend = 1'b0;
        end else begin
          if (m_pend) m_done = 1'b1;
          m_pend = 1'b1;
          m_end  = a + 16 * (int'(m_div) + 1);
          m_rx   = wd ^ {8{lb_inv}};
          x.tx = wd; x.h = int'(m_div) + 1; x.start = a;
          xfer_q.push_back(x);
        end
      end
      2'd1: begin
        if (rw) exp_rd = {5'b00000, m_div, m_cs};
        else begin m_cs = wd[0]; m_div = wd[2:1]; end
      end
      2'd2: if (rw) exp_rd = {6'b000000, m_done, m_pend};
      default: ;
    endcase
    e.rd = rw; e.data = exp_rd; e.cyc = a;
    bus_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge MB_CLK);
      if (DTACK_N == 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no DTACK_N within 400 cycles expected ack at cycle %0d", a);
      summary_and_finish();
    end
    ack_cyc = cyc;
    @(posedge MB_CLK); #1;
    SEL = 1'b0;
    #1 check_b("dtack_release", DTACK_N, 1'b1);
    if (r == 2'd1 && !rw) check_b("spi_cs", SPI_CS, ~m_cs);
    repeat (SYNC + 2) @(negedge MB_CLK);
  endtask

  // Bus monitor: every ack must match the next expected access
  bit prev_dtack = 1'b1;
  always @(negedge MB_CLK) begin
    if (!RESET) prev_dtack = 1'b1;
    else begin
      if (prev_dtack && !DTACK_N) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          check_i("ack_cycle", cyc, e.cyc);
          check_b("rdata_oe", RDATA_OE, e.rd);
          if (e.rd) check_8("rdata", RDATA, e.data);
        end
      end
      prev_dtack = DTACK_N;
    end
  end

  // SPI monitor: SCK edge timing and the serialised MOSI byte
  bit        prev_sck = 1'b0;
  int        pulse    = 0;
  logic [7:0] bits    = 8'h00;
  xfer_exp_t cur;
  always @(negedge MB_CLK) begin
    if (!RESET) begin
      prev_sck = 1'b0; pulse = 0;
    end else begin
      if (!prev_sck && SPI_SCK) begin
        if (pulse == 0) begin
          if (xfer_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_sck: got SCK rise at cycle %0d expected none", cyc);
            cur.tx = 8'h00; cur.h = 1; cur.start = cyc - 1;
          end else cur = xfer_q.pop_front();
        end
        check_i("sck_rise_cycle", cyc, cur.start + cur.h + 2 * cur.h * pulse);
        bits = {bits[6:0], SPI_MOSI};
      end
      if (prev_sck && !SPI_SCK) begin
        pulse++;
        if (pulse == 8) begin
          check_8("mosi_byte", bits, cur.tx);
          check_i("xfer_end_cycle", cyc, cur.start + 16 * cur.h);
          pulse = 0;
        end
      end
      prev_sck = SPI_SCK;
    end
  end

  initial begin
    int a;
    RESET = 1'b0; SEL = 1'b0; RW = 1'b0; REG = 2'd0; WDATA = 8'h00; lb_inv = 1'b0;
    model_reset();
    repeat (3) @(negedge MB_CLK);
    check_b("rst_dtack_n", DTACK_N, 1'b1);
    check_b("rst_spi_cs", SPI_CS, 1'b1);
    check_b("rst_sck", SPI_SCK, 1'b0);
    check_b("rst_mosi", SPI_MOSI, 1'b0);
    check_8("rst_rdata", RDATA, 8'hFF);
    RESET = 1'b1;
    repeat (2) @(negedge MB_CLK);

    access(1'b1, 2'd2, 8'h00, a);   // STATUS = 0x00
    access(1'b1, 2'd3, 8'h00, a);   // reserved = 0xFF
    access(1'b1, 2'd1, 8'h00, a);   // CTRL = 0x00
    access(1'b0, 2'd1, 8'h01, a);   // CS on, DIV=0

    // Loopback at DIV=0
    access(1'b0, 2'd0, 8'hA5, a);
    repeat (40) @(negedge MB_CLK);
    access(1'b1, 2'd2, 8'h00, a);   // DONE only
    access(1'b1, 2'd0, 8'h00, a);   // 0xA5
    access(1'b1, 2'd2, 8'h00, a);   // DONE cleared

    // DIV=3
    access(1'b0, 2'd1, 8'h07, a);
    access(1'b0, 2'd0, 8'h3C, a);
    repeat (80) @(negedge MB_CLK);
    access(1'b1, 2'd0, 8'h00, a);

    // Stalled write then stalled read
    access(1'b0, 2'd0, 8'h5A, a);
    access(1'b1, 2'd2, 8'h00, a);   // STATUS never stalls, shows BUSY
    access(1'b0, 2'd0, 8'h11, a);
    access(1'b1, 2'd0, 8'h00, a);
    access(1'b1, 2'd2, 8'h00, a);

    // Reserved write ignored
    access(1'b0, 2'd3, 8'h00, a);
    access(1'b1, 2'd1, 8'h00, a);

    // Reset in the middle of bit 4
    access(1'b0, 2'd1, 8'h03, a);   // CS on, DIV=1
    access(1'b0, 2'd0, 8'hFF, a);
    while (cyc < a + 17) @(negedge MB_CLK);
    @(posedge MB_CLK); #2;
    RESET = 1'b0;
    #1;
    check_b("midrst_dtack_n", DTACK_N, 1'b1);
    check_b("midrst_spi_cs", SPI_CS, 1'b1);
    check_b("midrst_sck", SPI_SCK, 1'b0);
    check_b("midrst_mosi", SPI_MOSI, 1'b0);
    check_8("midrst_rdata", RDATA, 8'hFF);
    model_reset();
    xfer_q.delete();
    bus_q.delete();
    repeat (3) @(negedge MB_CLK);
    @(posedge MB_CLK); #2;
    RESET = 1'b1;
    repeat (2) @(negedge MB_CLK);
    access(1'b1, 2'd2, 8'h00, a);   // BUSY=0, DONE=0
    access(1'b1, 2'd3, 8'h00, a);
    access(1'b1, 2'd0, 8'h00, a);   // RX cleared
    access(1'b1, 2'd1, 8'h00, a);
    access(1'b0, 2'd1, 8'h01, a);
    access(1'b0, 2'd0, 8'h96, a);
    repeat (30) @(negedge MB_CLK);
    access(1'b1, 2'd0, 8'h00, a);
    access(1'b1, 2'd2, 8'h00, a);

    // Randomised traffic with an inverting slave
    lb_inv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      logic       rw;
      logic [7:0] wd;
      r  = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      access(rw, r, wd, a);
      repeat ($urandom_range(0, 12)) @(negedge MB_CLK);
    end

    repeat (100) @(negedge MB_CLK);
    check_i("bus_queue_drained", bus_q.size(), 0);
    check_i("xfer_queue_drained", xfer_q.size(), 0);
    summary_and_finish();
  end

endmodule
`default_nettype wire
